// File: rtl/multi_issue_queue_pkg.sv
// +----------------------------------------------------------------------------+
// | multi_issue_queue_pkg                                                      |
// | Shared defaults and width helpers for the multi-lane issue queue.          |
// | Rev 1.0 - initial parametrised release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package multi_issue_queue_pkg;

  localparam int IQ_DEPTH_DEFAULT = 16;
  localparam int IQ_WIDTH_DEFAULT = 64;
  localparam int IQ_LANES_DEFAULT = 2;

  // IQ_ADDR width: pointer bits for a power-of-two depth
  function automatic int iq_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // IQ_COUNT width: must hold 0..depth inclusive
  function automatic int iq_count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_issue_queue_if.sv
// +----------------------------------------------------------------------------+
// | multi_issue_queue_if                                                       |
// | Push/pop/occupancy bundle between dispatch, the queue and issue.           |
// | Rev 1.0 - initial parametrised release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

interface multi_issue_queue_if
  import multi_issue_queue_pkg::*;
#(
  parameter int WIDTH     = IQ_WIDTH_DEFAULT,
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int IN_LANES  = IQ_LANES_DEFAULT,
  parameter int OUT_LANES = IQ_LANES_DEFAULT
) ();

  localparam int c_count_w = iq_count_w(DEPTH);
  localparam int c_in_n_w  = $clog2(IN_LANES + 1);
  localparam int c_out_n_w = $clog2(OUT_LANES + 1);

  logic                                flush;
  logic [IN_LANES-1:0][WIDTH-1:0]      in_data;
  logic [c_in_n_w-1:0]                 in_data_number;
  logic                                push_accept;
  logic [OUT_LANES-1:0][WIDTH-1:0]     out_data;
  logic [OUT_LANES-1:0]                out_valid;
  logic [c_out_n_w-1:0]                out_data_number;
  logic [c_count_w-1:0]                size;
  logic [c_count_w-1:0]                size_left;

  modport master (
    output flush, in_data, in_data_number, out_data_number,
    input  push_accept, out_data, out_valid, size, size_left
  );

  modport slave (
    input  flush, in_data, in_data_number, out_data_number,
    output push_accept, out_data, out_valid, size, size_left
  );

endinterface

`default_nettype wire

// File: rtl/multi_issue_queue_lane_index.sv
// +----------------------------------------------------------------------------+
// | iq_lane_index                                                              |
// | Maps a base pointer plus lane number to a wrapped address and lane enable. |
// | Rev 1.0 - initial parametrised release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module iq_lane_index
  import multi_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH_DEFAULT,
  parameter int LANES = IQ_LANES_DEFAULT,
  localparam int c_addr_w  = iq_addr_w(DEPTH),
  localparam int c_count_w = iq_count_w(DEPTH)
) (
  input  logic [c_addr_w-1:0]             i_base,
  input  logic [c_count_w-1:0]            i_count,
  output logic [LANES-1:0][c_addr_w-1:0]  o_addr,
  output logic [LANES-1:0]                o_en
);

  // Power-of-two depth lets the adder overflow do the modulo wrap
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign o_addr[i] = i_base + c_addr_w'(i);
    assign o_en[i]   = (c_count_w'(i) < i_count);
  end

endmodule

`default_nettype wire

// File: rtl/multi_issue_queue.sv
// +----------------------------------------------------------------------------+
// | multi_issue_queue                                                          |
// | Circular issue queue: up to IN_LANES pushes / OUT_LANES pops per cycle.    |
// | Optional IQ_STATS_EN adds reject_count and high_water outputs.             |
// | Rev 1.0 - initial parametrised release                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module multi_issue_queue
  import multi_issue_queue_pkg::*;
#(
  parameter int WIDTH     = IQ_WIDTH_DEFAULT,
  parameter int DEPTH     = IQ_DEPTH_DEFAULT,
  parameter int IN_LANES  = IQ_LANES_DEFAULT,
  parameter int OUT_LANES = IQ_LANES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  multi_issue_queue_if.slave            q
`ifdef IQ_STATS_EN
  ,
  output logic [31:0]                   reject_count,
  output logic [iq_count_w(DEPTH)-1:0]  high_water
`endif
);

  localparam int c_addr_w  = iq_addr_w(DEPTH);
  localparam int c_count_w = iq_count_w(DEPTH);

  typedef logic [c_addr_w-1:0]  iq_addr_t;
  typedef logic [c_count_w-1:0] iq_count_t;
  typedef logic [WIDTH-1:0]     issue_queue_element_t;

  localparam iq_count_t c_depth = iq_count_t'(DEPTH);

  issue_queue_element_t            r_mem [DEPTH];
  iq_addr_t                        r_head;
  iq_addr_t                        r_tail;
  iq_count_t                       r_size;
  iq_count_t                       r_size_left;

  iq_count_t                       w_push_req;
  iq_count_t                       w_pop_req;
  iq_count_t                       w_push_n;
  iq_count_t                       w_pop_n;
  iq_count_t                       w_size_next;
  logic                            w_push_accept;
  logic [IN_LANES-1:0][c_addr_w-1:0]  w_wr_addr;
  logic [IN_LANES-1:0]                w_wr_en;
  logic [OUT_LANES-1:0][c_addr_w-1:0] w_rd_addr;
  logic [OUT_LANES-1:0]               w_rd_en;

  assign w_push_req = iq_count_t'(q.in_data_number);
  assign w_pop_req  = iq_count_t'(q.out_data_number);

  // Judged against the registered headroom, ignoring any same-cycle pop
  assign w_push_accept = (w_push_req <= r_size_left) && !q.flush;
  assign w_push_n      = w_push_accept ? w_push_req : '0;
  assign w_pop_n       = (w_pop_req < r_size) ? w_pop_req : r_size;
  assign w_size_next   = r_size + w_push_n - w_pop_n;

  iq_lane_index #(.DEPTH(DEPTH), .LANES(IN_LANES)) u_wr_index (
    .i_base  (r_tail),
    .i_count (w_push_n),
    .o_addr  (w_wr_addr),
    .o_en    (w_wr_en)
  );

  iq_lane_index #(.DEPTH(DEPTH), .LANES(OUT_LANES)) u_rd_index (
    .i_base  (r_head),
    .i_count (r_size),
    .o_addr  (w_rd_addr),
    .o_en    (w_rd_en)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (w_wr_en[i]) begin
        r_mem[w_wr_addr[i]] <= q.in_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_size      <= '0;
      r_size_left <= c_depth;
    end else if (q.flush) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_size      <= '0;
      r_size_left <= c_depth;
    end else begin
      r_head      <= r_head + c_addr_w'(w_pop_n);
      r_tail      <= r_tail + c_addr_w'(w_push_n);
      r_size      <= w_size_next;
      r_size_left <= c_depth - w_size_next;
    end
  end

  for (genvar i = 0; i < OUT_LANES; i++) begin : g_rd_lane
    assign q.out_data[i]  = w_rd_en[i] ? r_mem[w_rd_addr[i]] : '0;
    assign q.out_valid[i] = w_rd_en[i];
  end

  assign q.push_accept = w_push_accept;
  assign q.size        = r_size;
  assign q.size_left   = r_size_left;

`ifdef IQ_STATS_EN
  logic [31:0] r_reject_count;
  iq_count_t   r_high_water;
  logic        w_reject;

  assign w_reject = (w_push_req != '0) && !w_push_accept;

  // Flush empties the queue but deliberately leaves the statistics intact
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reject_count <= '0;
      r_high_water   <= '0;
    end else begin
      if (w_reject && (r_reject_count != '1)) begin
        r_reject_count <= r_reject_count + 32'd1;
      end
      if (!q.flush && (w_size_next > r_high_water)) begin
        r_high_water <= w_size_next;
      end
    end
  end

  assign reject_count = r_reject_count;
  assign high_water   = r_high_water;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_issue_queue.sv
// +----------------------------------------------------------------------------+
// | tb_multi_issue_queue                                                       |
// | Directed self-checking bench for multi_issue_queue (16 deep, 2+2 lanes).   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multi_issue_queue;

  localparam int c_width = 64;
  localparam int c_depth = 16;
  localparam int c_lanes = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_issue_queue_if #(
    .WIDTH(c_width), .DEPTH(c_depth), .IN_LANES(c_lanes), .OUT_LANES(c_lanes)
  ) q_if ();

`ifdef IQ_STATS_EN
  logic [31:0] reject_count;
  logic [4:0]  high_water;
`endif

  multi_issue_queue #(
    .WIDTH(c_width), .DEPTH(c_depth), .IN_LANES(c_lanes), .OUT_LANES(c_lanes)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (q_if)
`ifdef IQ_STATS_EN
    ,
    .reject_count (reject_count),
    .high_water   (high_water)
`endif
  );

  int err_cnt  = 0;
  int chk_cnt  = 0;
  int wr_k     = 0;
  int rd_k     = 0;
  int cur_size = 0;

  function automatic logic [63:0] item(input int k);
    return 64'hA5A5_0000_0000_0000 | 64'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n_push, input int n_pop, input logic do_flush);
    q_if.in_data[0]       = item(wr_k);
    q_if.in_data[1]       = item(wr_k + 1);
    q_if.in_data_number   = 2'(n_push);
    q_if.out_data_number  = 2'(n_pop);
    q_if.flush            = do_flush;
  endtask

  task automatic check_view(input int exp_size);
    check("size",       64'(q_if.size),      64'(exp_size));
    check("size_left",  64'(q_if.size_left), 64'(c_depth - exp_size));
    check("out_valid",  64'(q_if.out_valid), 64'({exp_size >= 2, exp_size >= 1}));
    check("out_data0",  q_if.out_data[0],    (exp_size >= 1) ? item(rd_k)     : 64'd0);
    check("out_data1",  q_if.out_data[1],    (exp_size >= 2) ? item(rd_k + 1) : 64'd0);
  endtask

  // One clock: drive, check push_accept, clock, then check the hand-given size
  task automatic cycle(input int n_push, input int n_pop, input logic exp_acc, input int exp_size);
    int acc_n;
    drive(n_push, n_pop, 1'b0);
    #1;
    check("push_accept", 64'(q_if.push_accept), 64'(exp_acc));
    @(posedge clk);
    #1;
    acc_n = exp_acc ? n_push : 0;
    wr_k += acc_n;
    rd_k += cur_size + acc_n - exp_size;
    cur_size = exp_size;
    drive(0, 0, 1'b0);
    check_view(exp_size);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_view(0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n <= 2; n++) begin
      drive(n, 0, 1'b0);
      #1;
      check("idle_accept", 64'(q_if.push_accept), 64'd1);
    end
    drive(0, 0, 1'b0);
    @(posedge clk);
    #1;

    cycle(2, 0, 1'b1, 2);
    cycle(2, 0, 1'b1, 4);
    for (int i = 0; i < 6; i++) cycle(2, 0, 1'b1, 6 + 2 * i);

    cycle(1, 0, 1'b0, 16);
    cycle(0, 0, 1'b1, 16);
    cycle(2, 2, 1'b0, 14);
    cycle(2, 0, 1'b1, 16);
`ifdef IQ_STATS_EN
    check("reject_count_full", 64'(reject_count), 64'd2);
    check("high_water_full",   64'(high_water),   64'd16);
`endif

    cycle(0, 2, 1'b1, 14);
    for (int i = 0; i < 40; i++) cycle(2, 2, 1'b1, 14);

    for (int i = 0; i < 6; i++) cycle(0, 2, 1'b1, 12 - 2 * i);
    cycle(0, 1, 1'b1, 1);
    cycle(0, 2, 1'b1, 0);
    cycle(0, 2, 1'b1, 0);

    cycle(2, 0, 1'b1, 2);
    cycle(2, 0, 1'b1, 4);
    #2;
    rst = 1'b0;
    #1;
    rd_k     = wr_k;
    cur_size = 0;
    check_view(0);
`ifdef IQ_STATS_EN
    check("reject_count_rst", 64'(reject_count), 64'd0);
    check("high_water_rst",   64'(high_water),   64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) cycle(2, 0, 1'b1, 2 + 2 * i);
    cycle(1, 0, 1'b1, 9);

    drive(2, 0, 1'b1);
    #1;
    check("flush_accept", 64'(q_if.push_accept), 64'd0);
    @(posedge clk);
    #1;
    drive(0, 0, 1'b0);
    rd_k     = wr_k;
    cur_size = 0;
    check_view(0);
`ifdef IQ_STATS_EN
    check("reject_count_flush", 64'(reject_count), 64'd1);
    check("high_water_flush",   64'(high_water),   64'd9);
`endif
    cycle(2, 0, 1'b1, 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_issue_queue.md
Name: multi_issue_queue

Overview:
Parametrised successor to the fixed two-lane issue_queue, sitting between decode/dispatch and issue in the MeMIPS pipeline.
- Circular FIFO of issue-queue elements.
- Accepts up to IN_LANES pushes and retires up to OUT_LANES pops per cycle.
- Adds the following, which the old queue lacks: a flush input, all-or-nothing push acceptance, pop clamping, and per-lane valid flags.
- Exports size and size_left exactly as issue already consumes them.

Parameters:
WIDTH, 64, bit width of one queue element (ISSUE_QUEUE_ELEMENT payload)
DEPTH, 16, number of entries; power of two, >= max(IN_LANES, OUT_LANES)
IN_LANES, 2, maximum pushes per cycle
OUT_LANES, 2, maximum pops per cycle

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  discard all contents at next edge
in_data  input  IN_LANES x WIDTH  push payload; lane 0 is oldest
in_data_number  input  clog2(IN_LANES+1)  number of lanes to push (0..IN_LANES)
push_accept  output  1  combinational: push this cycle will be taken
out_data  output  OUT_LANES x WIDTH  head entries; lane 0 is oldest
out_valid  output  OUT_LANES  lane i holds a real entry (i < size)
out_data_number  input  clog2(OUT_LANES+1)  number of entries consumer pops this cycle
size  output  clog2(DEPTH+1)  occupied entries (registered)
size_left  output  clog2(DEPTH+1)  DEPTH - size (registered)

Behaviour:
- Reset (rst=0, async):
  - head=0, tail=0, size=0, size_left=DEPTH.
  - out_valid=0, out_data=0.
  - Storage contents are don't-care.
- Pointers:
  - head and tail are clog2(DEPTH) bits and wrap modulo DEPTH naturally.
  - Lane i addresses (ptr+i) mod DEPTH.
- Push:
  - push_accept = (in_data_number <= size_left) and !flush.
  - Accept is all-or-nothing; a partial push never happens.
  - When accepted, lanes 0..n-1 are written at tail..tail+n-1, and tail += n.
  - When rejected, nothing is written; the producer holds and retries.
- Pop:
  - Effective pop count p = min(out_data_number, size). Over-requests are clamped silently.
  - head += p.
- Head view:
  - out_data[i] is a combinational read of entry head+i.
  - out_valid[i] = (i < size). Lanes with i >= size drive out_data=0.
- Occupancy:
  - size_next = size + accepted_n - p.
  - size_left is always DEPTH - size.
  - Both are registered, so a push is visible one cycle later (latency 1). No same-cycle bypass into out_data.
- Simultaneous push and pop:
  - push_accept is computed from the registered size_left, not the post-pop value. This is conservative and keeps timing flat.
  - Full queue (size=DEPTH) with a pop of 2 and a push of 2: the push is rejected this cycle.
- Flush:
  - Has priority over push and pop.
  - Next edge: head=tail=0, size=0, size_left=DEPTH.
  - The push is ignored; push_accept=0 during the flush cycle.
- Empty queue: out_valid all 0; pops are clamped to 0.
- Full queue: size_left=0; any in_data_number>0 is rejected; in_data_number=0 is accepted as a no-op.
- Reset asserted mid-operation: the queue is emptied immediately and asynchronously; in-flight pushes are lost.

Optional Feature:
Macro IQ_STATS_EN.
- Defined:
  - Extra output reject_count (32 bits), incremented each cycle a push with in_data_number>0 is rejected. Saturates at all-ones.
  - Extra output high_water (clog2(DEPTH+1) bits), the maximum size reached since reset.
  - Both clear on rst; flush does not clear them.
- Undefined: neither port nor its logic exists.

Decomposition:
- defines.svh gets:
  - IQ_ADDR generalised to clog2(DEPTH) width.
  - An IQ_COUNT type of clog2(DEPTH+1) width.
  - ISSUE_QUEUE_ELEMENT stays the WIDTH payload.
  - A constant IQ_DEPTH_DEFAULT=16.
- One natural sub-module, iq_lane_index: maps (base pointer, lane) to a wrapped address and per-lane enables. It is instantiated once for the write side and once for the read side.

Test Plan:
- Reset, then idle → size=0, size_left=16, out_valid=00, push_accept=1 for in_data_number=0..2.
- Push A,B, then next cycle push C,D → size 2 then 4; out_data={A,B} with out_valid=11 one cycle after the first push.
- Fill to 16, then push 1 → push_accept=0, size stays 16. Pop 2 while pushing 2 in the same cycle → push rejected, size=14. Retry → accepted, size=16.
- Wrap-around: pop and push 2 per cycle for 40 cycles → FIFO order preserved across pointer wrap; size constant.
- Size=1 (entry X), pop request 2 → p=1, out_valid was 01 with out_data[1]=0, next size=0.
- Size=9 with push 2 and flush high together → next size=0, size_left=16, push_accept=0 in the flush cycle. With IQ_STATS_EN, high_water=9 is retained; a rejected push increments reject_count by 1.
